// File: rtl/mmio_csr_bank_if.sv
// MMIO request/response and forwarded-write packet bundle between the host
// side (master) and the CSR bank (slave).
interface mmio_csr_bank_if;
  logic        mmio_rd_valid;
  logic        mmio_wr_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wdata;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [15:0] pkt_addr;
  logic [63:0] pkt_data;

  modport master (
    output mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_tid, mmio_wdata, pkt_ready,
    input  rsp_valid, rsp_tid, rsp_data, pkt_valid, pkt_addr, pkt_data
  );

  modport slave (
    input  mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_tid, mmio_wdata, pkt_ready,
    output rsp_valid, rsp_tid, rsp_data, pkt_valid, pkt_addr, pkt_data
  );
endinterface

// File: rtl/mmio_csr_bank.sv
// MMIO CSR responder: answers host reads (DFH, AFU ID, control, status, FIFO
// status) with two-cycle latency and forwards host writes to the template
// through a small valid/ready queue with a saturating drop counter.
module mmio_csr_bank #(
  parameter int           NUM_CTRL   = 4,
  parameter int           NUM_STAT   = 4,
  parameter logic [15:0]  CTRL_BASE  = 16'h040,
  parameter logic [15:0]  STAT_BASE  = 16'h0C0,
  parameter logic [15:0]  FSTAT_ADDR = 16'h0F0,
  parameter logic [15:0]  ADDR_LIMIT = 16'h100,
  parameter logic [127:0] AFU_ID     = 128'hC000C966_0D82_4272_9AEF_FE5F84570612,
  parameter int           FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mmio_csr_bank_if.slave         bus,
  input  logic [NUM_STAT*64-1:0] stat_in,
  output logic [NUM_CTRL*64-1:0] ctrl_out
);

  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam int          LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [63:0] DFH   = 64'h1000000010000000;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                   rd_vld_p0, wr_vld_p0;
  logic [15:0]            addr_p0;
  logic [8:0]             tid_p0;
  logic [63:0]            wdata_p0;
  logic [NUM_STAT*64-1:0] stat_snap;

  logic                   rsp_vld_p1;
  logic [8:0]             rsp_tid_p1;
  logic [63:0]            rsp_data_p1;

  logic [63:0]            ctrl_q [NUM_CTRL];
  logic [NUM_CTRL-1:0]    ctrl_wr_hit;

  logic [79:0]            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [LVL_W-1:0]       level;
  logic [15:0]            drop_cnt;
  logic [7:0]             level8;

  logic                   rd_hit, fstat_wr, push_req, push, pop, drop, full, empty;
  logic [63:0]            rd_data;

  // Stage R: register the host request and snapshot the status inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_p0 <= 1'b0;
      wr_vld_p0 <= 1'b0;
      addr_p0   <= '0;
      tid_p0    <= '0;
      wdata_p0  <= '0;
      stat_snap <= '0;
    end else begin
      rd_vld_p0 <= bus.mmio_rd_valid;
      wr_vld_p0 <= bus.mmio_wr_valid;
      addr_p0   <= bus.mmio_addr;
      tid_p0    <= bus.mmio_tid;
      wdata_p0  <= bus.mmio_wdata;
      stat_snap <= stat_in;
    end
  end

  assign level8   = 8'(level);
  assign full     = (level == LVL_W'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign rd_hit   = rd_vld_p0 && (addr_p0 < ADDR_LIMIT);
  assign fstat_wr = wr_vld_p0 && (addr_p0 == FSTAT_ADDR);
  assign push_req = wr_vld_p0 && !fstat_wr;
  assign pop      = !empty && bus.pkt_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Read-data mux and control-slot write decode for the request in stage R
  always_comb begin
    rd_data     = '0;
    ctrl_wr_hit = '0;
    if (addr_p0 == 16'h0000) rd_data = DFH;
    if (addr_p0 == 16'h0002) rd_data = AFU_ID[63:0];
    if (addr_p0 == 16'h0004) rd_data = AFU_ID[127:64];
    if (addr_p0 == FSTAT_ADDR) rd_data = {32'b0, drop_cnt, 8'b0, level8};
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (addr_p0 == CTRL_BASE + 16'(2 * i)) begin
        rd_data        = ctrl_q[i];
        ctrl_wr_hit[i] = wr_vld_p0;
      end
    end
    for (int i = 0; i < NUM_STAT; i++) begin
      if (addr_p0 == STAT_BASE + 16'(2 * i)) rd_data = stat_snap[64*i +: 64];
    end
  end

  // Response stage: one registered response per answered read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_vld_p1  <= 1'b0;
      rsp_tid_p1  <= '0;
      rsp_data_p1 <= '0;
    end else begin
      rsp_vld_p1 <= rd_hit;
      if (rd_hit) begin
        rsp_tid_p1  <= tid_p0;
        rsp_data_p1 <= rd_data;
      end
    end
  end

  // Control registers; a read in the same cycle sees the old value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (ctrl_wr_hit[i]) ctrl_q[i] <= wdata_p0;
      end
    end
  end

  // Write queue storage, pointers, occupancy and sticky drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {addr_p0, wdata_p0};
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
      if (fstat_wr) drop_cnt <= '0;
      else if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
    assign ctrl_out[64*g +: 64] = ctrl_q[g];
  end

  assign bus.rsp_valid = rsp_vld_p1;
  assign bus.rsp_tid   = rsp_tid_p1;
  assign bus.rsp_data  = rsp_data_p1;
  assign bus.pkt_valid = !empty;
  assign bus.pkt_addr  = fifo_mem[rd_ptr][79:64];
  assign bus.pkt_data  = fifo_mem[rd_ptr][63:0];

endmodule

// File: tb/tb_mmio_csr_bank.sv
// Directed bench for mmio_csr_bank: read responses and forwarded write
// packets are checked against expectation queues filled as stimulus is driven.
module tb_mmio_csr_bank;

  localparam logic [63:0] DFH = 64'h1000000010000000;
  localparam logic [63:0] AFU_LO = 64'h9AEFFE5F84570612;
  localparam logic [63:0] AFU_HI = 64'hC000C9660D824272;
  localparam logic [15:0] FSTAT = 16'h0F0;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } pkt_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] stat_in;
  logic [255:0] ctrl_out;
  int           cyc = 0;
  int           vectors = 0;
  int           errs = 0;
  rsp_t         exp_rsp [$];
  pkt_t         exp_pkt [$];
  rsp_t         r_m;
  pkt_t         p_m;

  mmio_csr_bank_if bus ();

  mmio_csr_bank dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .stat_in  (stat_in),
    .ctrl_out (ctrl_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fstat_val(input logic [15:0] drops, input logic [7:0] lvl);
    return {32'b0, drops, 8'b0, lvl};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.mmio_rd_valid = 1'b0;
      bus.mmio_wr_valid = 1'b0;
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [8:0] t, input logic [63:0] d, input bit ans);
    @(posedge clk); #1;
    bus.mmio_rd_valid = 1'b1;
    bus.mmio_wr_valid = 1'b0;
    bus.mmio_addr     = a;
    bus.mmio_tid      = t;
    if (ans) exp_rsp.push_back('{t, d, cyc});
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d, input bit enq);
    @(posedge clk); #1;
    bus.mmio_rd_valid = 1'b0;
    bus.mmio_wr_valid = 1'b1;
    bus.mmio_addr     = a;
    bus.mmio_wdata    = d;
    if (enq) exp_pkt.push_back('{a, d});
  endtask

  task automatic rdwr(input logic [15:0] a, input logic [8:0] t, input logic [63:0] drd,
                      input logic [63:0] dwr);
    @(posedge clk); #1;
    bus.mmio_rd_valid = 1'b1;
    bus.mmio_wr_valid = 1'b1;
    bus.mmio_addr     = a;
    bus.mmio_tid      = t;
    bus.mmio_wdata    = dwr;
    exp_rsp.push_back('{t, drd, cyc});
    exp_pkt.push_back('{a, dwr});
  endtask

  // Response and packet monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.rsp_valid) begin
        vectors++;
        assert (exp_rsp.size() != 0) else begin
          errs++;
          $error("FAIL rsp_unexpected observed tid=%0h data=%0h expected no response",
                 bus.rsp_tid, bus.rsp_data);
        end
        if (exp_rsp.size() != 0) begin
          r_m = exp_rsp.pop_front();
          chk("rsp_tid_data", {bus.rsp_tid, bus.rsp_data}, {r_m.tid, r_m.data});
          chk("rsp_latency", 256'(cyc - r_m.cyc), 256'd2);
        end
      end
      if (bus.pkt_valid && bus.pkt_ready) begin
        vectors++;
        assert (exp_pkt.size() != 0) else begin
          errs++;
          $error("FAIL pkt_unexpected observed addr=%0h data=%0h expected no packet",
                 bus.pkt_addr, bus.pkt_data);
        end
        if (exp_pkt.size() != 0) begin
          p_m = exp_pkt.pop_front();
          chk("pkt_addr_data", {bus.pkt_addr, bus.pkt_data}, {p_m.addr, p_m.data});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n           = 1'b0;
    stat_in           = '0;
    bus.mmio_rd_valid = 1'b0;
    bus.mmio_wr_valid = 1'b0;
    bus.mmio_addr     = '0;
    bus.mmio_tid      = '0;
    bus.mmio_wdata    = '0;
    bus.pkt_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 256'(bus.rsp_valid), 256'd0);
    chk("rst_rsp_tid", 256'(bus.rsp_tid), 256'd0);
    chk("rst_rsp_data", 256'(bus.rsp_data), 256'd0);
    chk("rst_pkt_valid", 256'(bus.pkt_valid), 256'd0);
    chk("rst_pkt_addr", 256'(bus.pkt_addr), 256'd0);
    chk("rst_pkt_data", 256'(bus.pkt_data), 256'd0);
    chk("rst_ctrl_out", ctrl_out, 256'd0);
    reset_n = 1'b1;

    // back-to-back header reads
    rd(16'h000, 9'h001, DFH, 1);
    rd(16'h002, 9'h002, AFU_LO, 1);
    rd(16'h004, 9'h003, AFU_HI, 1);
    rd(16'h006, 9'h004, 64'h0, 1);
    idle(4);

    // control write, readback and forwarded packet
    wr(16'h042, 64'hDEAD_BEEF, 1);
    idle(1);
    chk("ctrl1_not_yet", 256'(ctrl_out[127:64]), 256'd0);
    idle(1);
    chk("ctrl1_updated", 256'(ctrl_out[127:64]), 256'hDEAD_BEEF);
    rd(16'h042, 9'h005, 64'hDEAD_BEEF, 1);
    idle(4);

    // overfill the queue with the consumer stalled
    bus.pkt_ready = 1'b0;
    for (int i = 0; i < 10; i++) wr(16'h200 + 16'(i), 64'h100 + 64'(i), i < 8);
    idle(3);
    chk("full_pkt_valid", 256'(bus.pkt_valid), 256'd1);
    chk("full_head", {bus.pkt_addr, bus.pkt_data}, {16'h200, 64'h100});
    rd(FSTAT, 9'h020, fstat_val(16'd2, 8'd8), 1);
    idle(3);
    chk("stalled_head", {bus.pkt_addr, bus.pkt_data}, {16'h200, 64'h100});

    // push and pop on the same edge while full
    wr(16'h300, 64'hABC, 1);
    @(posedge clk); #1;
    bus.mmio_wr_valid = 1'b0;
    bus.pkt_ready     = 1'b1;
    @(posedge clk); #1;
    bus.pkt_ready     = 1'b0;
    idle(2);
    rd(FSTAT, 9'h021, fstat_val(16'd2, 8'd8), 1);
    idle(3);
    chk("head_after_pop", 256'(bus.pkt_addr), 256'h201);

    // drop counter clear, not forwarded
    wr(FSTAT, 64'h0, 0);
    idle(2);
    rd(FSTAT, 9'h022, fstat_val(16'd0, 8'd8), 1);
    idle(3);
    bus.pkt_ready = 1'b1;
    idle(12);
    chk("drained_pkt_valid", 256'(bus.pkt_valid), 256'd0);

    // address limit, odd address, status snapshot, read/write collision
    rd(16'h100, 9'h030, 64'h0, 0);
    rd(16'h003, 9'h031, 64'h0, 1);
    stat_in[128 +: 64] = 64'd5;
    idle(2);
    rd(16'h0C4, 9'h032, 64'd5, 1);
    rdwr(16'h042, 9'h033, 64'hDEAD_BEEF, 64'h1234);
    rd(16'h042, 9'h034, 64'h1234, 1);
    idle(4);

    // reset with a read in flight and three queued writes
    bus.pkt_ready = 1'b0;
    wr(16'h040, 64'h55, 1);
    wr(16'h400, 64'h1, 1);
    wr(16'h401, 64'h2, 1);
    rd(16'h000, 9'h01F, DFH, 0);
    @(posedge clk); #1;
    bus.mmio_rd_valid = 1'b0;
    bus.mmio_wr_valid = 1'b0;
    chk("pre_rst_pkt_valid", 256'(bus.pkt_valid), 256'd1);
    chk("pre_rst_ctrl0", 256'(ctrl_out[63:0]), 256'h55);
    reset_n = 1'b0;
    exp_pkt.delete();
    idle(2);
    chk("mid_rst_rsp_valid", 256'(bus.rsp_valid), 256'd0);
    chk("mid_rst_pkt_valid", 256'(bus.pkt_valid), 256'd0);
    chk("mid_rst_ctrl_out", ctrl_out, 256'd0);
    reset_n       = 1'b1;
    bus.pkt_ready = 1'b1;
    idle(5);
    chk("post_rst_pkt_valid", 256'(bus.pkt_valid), 256'd0);
    chk("rsp_outstanding", 256'(exp_rsp.size()), 256'd0);
    chk("pkt_outstanding", 256'(exp_pkt.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
